// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter for the icache/dcache pair: dcache has priority, a
// starvation streak counter forces an icache grant after STARVE_MAX dcache wins.
module cache_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic [1:0]        owner,
    output logic              ram_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [3:0] STREAK_LIM = 4'(STARVE_MAX);

    state_t      state_reg, state_next;
    logic [3:0]  streak_reg, streak_next;
    logic        ram_err_reg, ram_err_next;

    logic        dreq;
    logic        ram_access;
    logic        i_starved;

    assign dreq       = dREN | dWEN;
    assign ram_access = (ramstate == RAM_ACCESS);
    assign i_starved  = iREN && (streak_reg == STREAK_LIM);

    // Read data is a pure pass-through; each cache qualifies it with its wait.
    assign iload   = ramload;
    assign dload   = ramload;
    assign owner   = state_reg;
    assign ram_err = ram_err_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            streak_reg  <= 4'd0;
            ram_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            streak_reg  <= streak_next;
            ram_err_reg <= ram_err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        streak_next  = streak_reg;
        ram_err_next = 1'b0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        iwait        = 1'b1;
        dwait        = 1'b1;

        unique case (state_reg)
            IDLE: begin
                if (dreq && !i_starved) begin
                    state_next = DGNT;
                end else if (iREN) begin
                    state_next = IGNT;
                end
            end

            IGNT: begin
                ramREN       = iREN;
                ramaddr      = iaddr;
                ram_err_next = (ramstate == RAM_ERROR);
                if (!iREN) begin
                    // Withdrawn: strobe already low, nothing completes.
                    state_next = IDLE;
                end else if (ram_access) begin
                    iwait       = 1'b0;
                    state_next  = IDLE;
                    streak_next = 4'd0;
                end
            end

            DGNT: begin
                ramWEN       = dWEN;
                ramREN       = dREN & ~dWEN;
                ramaddr      = daddr;
                ramstore     = dstore;
                ram_err_next = (ramstate == RAM_ERROR);
                if (!dreq) begin
                    state_next = IDLE;
                end else if (ram_access) begin
                    dwait      = 1'b0;
                    state_next = IDLE;
                    // Only count dcache wins that actually kept icache waiting.
                    if (!iREN) begin
                        streak_next = 4'd0;
                    end else if (streak_reg != STREAK_LIM) begin
                        streak_next = streak_reg + 4'd1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: per-cycle behavioural model plus
// directed scenarios with hand-computed expectations, then random traffic.
module tb_cache_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          iwait;
    logic [DW-1:0] iload;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic          dwait;
    logic [DW-1:0] dload;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;
    logic [1:0]    ramstate;
    logic [1:0]    owner;
    logic          ram_err;

    int errors = 0;
    int checks = 0;

    cache_mem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .STARVE_MAX(SMAX)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .iREN(iREN),
        .iaddr(iaddr),
        .iwait(iwait),
        .iload(iload),
        .dREN(dREN),
        .dWEN(dWEN),
        .daddr(daddr),
        .dstore(dstore),
        .dwait(dwait),
        .dload(dload),
        .ramREN(ramREN),
        .ramWEN(ramWEN),
        .ramaddr(ramaddr),
        .ramstore(ramstore),
        .ramload(ramload),
        .ramstate(ramstate),
        .owner(owner),
        .ram_err(ram_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Grant holder: 0 none, 1 icache, 2 dcache. streak counts dcache wins over a waiting icache.
    int m_own = 0;
    int m_streak = 0;
    bit m_err = 0;
    bit m_valid = 0;
    int n_own = 0;
    int n_streak = 0;
    bit n_err = 0;

    always @(posedge CLK) begin
        if (RST) begin
            m_own = 0; m_streak = 0; m_err = 0; m_valid = 1;
        end else if (m_valid) begin
            m_own = n_own; m_streak = n_streak; m_err = n_err;
        end
    end

    always @(negedge CLK) begin
        bit dreq, owner_req, done, granted;
        logic          e_ren, e_wen, e_iw, e_dw;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_store;
        if (m_valid) begin
            dreq      = dREN || dWEN;
            granted   = (m_own != 0);
            owner_req = (m_own == 1) ? iREN : (m_own == 2) ? dreq : 1'b0;
            done      = granted && owner_req && (ramstate == 2'd2);

            e_ren   = (m_own == 1) ? iREN : (m_own == 2) ? (dREN && !dWEN) : 1'b0;
            e_wen   = (m_own == 2) ? dWEN : 1'b0;
            e_addr  = (m_own == 1) ? iaddr : (m_own == 2) ? daddr : '0;
            e_store = (m_own == 2) ? dstore : '0;
            e_iw    = !(done && m_own == 1);
            e_dw    = !(done && m_own == 2);

            check("owner", owner, m_own);
            check("ramREN", ramREN, e_ren);
            check("ramWEN", ramWEN, e_wen);
            check("ramaddr", ramaddr, e_addr);
            if (m_own != 1) check("ramstore", ramstore, e_store);
            check("iwait", iwait, e_iw);
            check("dwait", dwait, e_dw);
            check("iload", iload, ramload);
            check("dload", dload, ramload);
            check("ram_err", ram_err, m_err);

            n_err = granted && (ramstate == 2'd3);
            if (!granted)
                n_own = (dreq && !(iREN && m_streak == SMAX)) ? 2 : (iREN ? 1 : 0);
            else if (!owner_req || done)
                n_own = 0;
            else
                n_own = m_own;
            n_streak = m_streak;
            if (done) n_streak = (m_own == 2 && iREN) ? ((m_streak + 1 > SMAX) ? SMAX : m_streak + 1) : 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0; dstore = '0;
        ramstate = 2'd0; ramload = '0; RST = 0;
    endtask

    int exp_own [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    initial begin
        idle_inputs();
        // Reset with every request asserted.
        RST = 1; iREN = 1; dREN = 1; dWEN = 1; iaddr = 32'h44; daddr = 32'h88; dstore = 32'h5A5A;
        next_cycle();
        next_cycle();
        @(negedge CLK);
        check("rst_owner", owner, 2'd0);
        check("rst_iwait", iwait, 1'b1);
        check("rst_dwait", dwait, 1'b1);
        check("rst_ramREN", ramREN, 1'b0);
        check("rst_ramWEN", ramWEN, 1'b0);
        check("rst_ramaddr", ramaddr, 32'h0);
        check("rst_ramstore", ramstore, 32'h0);
        check("rst_ram_err", ram_err, 1'b0);
        next_cycle();
        idle_inputs();
        next_cycle();

        // Lone icache read: two BUSY cycles, then ACCESS.
        for (int k = 0; k < 5; k++) begin
            iREN = (k < 4); iaddr = 32'h40; ramload = 32'hDEADBEEF;
            ramstate = (k == 1 || k == 2) ? 2'd1 : (k == 3) ? 2'd2 : 2'd0;
            @(negedge CLK);
            check("lone_iwait", iwait, (k == 3) ? 1'b0 : 1'b1);
            check("lone_dwait", dwait, 1'b1);
            if (k == 3) check("lone_iload", iload, 32'hDEADBEEF);
            if (k == 1) check("lone_ramaddr", ramaddr, 32'h40);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // Contention with instant ACCESS: the starvation counter lets icache in every fifth grant.
        iREN = 1; dREN = 1; iaddr = 32'h80; daddr = 32'h200; ramstate = 2'd2;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            check("cont_owner", owner, (k % 2 == 1) ? 2'(exp_own[k / 2]) : 2'd0);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // dcache write wins over read, then a read that is withdrawn while BUSY.
        dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'h12345678;
        @(negedge CLK);
        next_cycle();
        ramstate = 2'd1;
        @(negedge CLK);
        check("wr_ramWEN", ramWEN, 1'b1);
        check("wr_ramREN", ramREN, 1'b0);
        check("wr_ramaddr", ramaddr, 32'h100);
        check("wr_ramstore", ramstore, 32'h12345678);
        next_cycle();
        dWEN = 0;
        @(negedge CLK);
        check("rd_ramREN", ramREN, 1'b1);
        next_cycle();
        dREN = 0;
        @(negedge CLK);
        check("wd_ramREN", ramREN, 1'b0);
        check("wd_dwait", dwait, 1'b1);
        next_cycle();
        ramstate = 2'd0;
        @(negedge CLK);
        check("wd_owner", owner, 2'd0);
        check("wd_dwait_after", dwait, 1'b1);
        next_cycle();

        // One ERROR cycle, then ACCESS.
        dREN = 1; daddr = 32'h300;
        next_cycle();
        ramstate = 2'd3;
        @(negedge CLK);
        check("err_dwait", dwait, 1'b1);
        check("err_pulse_before", ram_err, 1'b0);
        next_cycle();
        ramstate = 2'd2;
        @(negedge CLK);
        check("err_pulse", ram_err, 1'b1);
        check("err_dwait_done", dwait, 1'b0);
        next_cycle();
        dREN = 0; ramstate = 2'd0;
        @(negedge CLK);
        check("err_pulse_after", ram_err, 1'b0);
        next_cycle();

        // Reset while icache holds the grant.
        iREN = 1; iaddr = 32'h500; ramstate = 2'd1;
        next_cycle();
        @(negedge CLK);
        check("rstg_owner_before", owner, 2'd1);
        next_cycle();
        RST = 1;
        next_cycle();
        RST = 0;
        @(negedge CLK);
        check("rstg_owner", owner, 2'd0);
        check("rstg_ramREN", ramREN, 1'b0);
        next_cycle();
        idle_inputs();
        next_cycle();

        // Random traffic; the model checks every cycle.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 3) == 0) iREN = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) dREN = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) dWEN = $urandom_range(0, 1);
            iaddr    = $urandom;
            daddr    = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            ramstate = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            RST      = ($urandom_range(0, 299) == 0);
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
